shift_arb: RTL and testbench

SHIFT_ARB -- requirements
Module: shift_arb

---
 rtl/shift_arb_pkg.sv | 31 +++
 rtl/shift_rr_pick.sv | 21 ++
 rtl/shift_arb.sv | 112 +++++++++++
 tb/tb_shift_arb.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arb_pkg.sv
// Shared types for the shift arbiter: shift-op encoding, response record and the shift datapath.
package shift_arb_pkg;

    localparam int TAG_MAX_W = 16;

    typedef enum logic [1:0] {
        SH_LUI = 2'b00,
        SH_SLL = 2'b01,
        SH_SRA = 2'b10,
        SH_SRL = 2'b11
    } shift_op_e;

    // Tag field is sized for the widest supported TAG_W; the top uses the low TAG_W bits.
    typedef struct packed {
        logic [31:0]          data;
        logic                 id;
        logic [TAG_MAX_W-1:0] tag;
    } resp_t;

    function automatic logic [31:0] shift_calc(shift_op_e op, logic [31:0] a, logic [4:0] b);
        logic [31:0] r;
        case (op)
            SH_LUI:  r = {a[15:0], 16'h0000};
            SH_SLL:  r = a << b;
            SH_SRA:  r = 32'($signed(a) >>> b);
            default: r = a >> b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_rr_pick.sv
// Two-requester grant: single valid wins outright, contention goes to the requester not named by ptr_i.
// Purely combinational; no grant at all while en_i is low.
module shift_rr_pick (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (valid_i == 2'b11) begin
                grant_o = ptr_i ? 2'b01 : 2'b10;
            end else begin
                grant_o = valid_i;
            end
        end
    end

endmodule

// File: rtl/shift_arb.sv
// Two-requester shifter with one result slot; 1-cycle latency, ready only when the slot is free or draining.
// SHIFT_ARB_RR_EN selects round-robin arbitration; otherwise req0 has fixed priority.
module shift_arb
    import shift_arb_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_srca,
    input  logic [4:0]       req0_srcb,
    input  logic [1:0]       req0_func,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_srca,
    input  logic [4:0]       req1_srcb,
    input  logic [1:0]       req1_func,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag
);

    logic       resp_vld_q, resp_vld_d;
    resp_t      resp_q, resp_d;
    logic       slot_free;
    logic       pick_en;
    logic       pick_ptr;
    logic [1:0] grant;
    logic       accept;
    logic       sel1;

    assign slot_free = ~resp_vld_q | resp_ready;
    // rst is folded in so nothing is offered while reset is held, even before the first edge.
    assign pick_en   = slot_free & ~flush & ~rst;

`ifdef SHIFT_ARB_RR_EN
    logic last_q, last_d;

    assign last_d = accept ? grant[1] : last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign pick_ptr = last_q;
`else
    assign pick_ptr = 1'b1;
`endif

    shift_rr_pick u_pick (
        .valid_i ( {req1_valid, req0_valid}),
        .ptr_i   (pick_ptr),
        .en_i    (pick_en),
        .grant_o (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign sel1       = grant[1];

    always_comb begin
        resp_d      = resp_q;
        resp_d.data = sel1 ? shift_calc(shift_op_e'(req1_func), req1_srca, req1_srcb)
                           : shift_calc(shift_op_e'(req0_func), req0_srca, req0_srcb);
        resp_d.id   = sel1;
        resp_d.tag  = TAG_MAX_W'(sel1 ? req1_tag : req0_tag);
    end

    always_comb begin
        resp_vld_d = resp_vld_q;
        if (flush) begin
            resp_vld_d = 1'b0;
        end else if (accept) begin
            resp_vld_d = 1'b1;
        end else if (resp_ready) begin
            resp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_vld_q <= 1'b0;
            resp_q     <= '0;
        end else begin
            resp_vld_q <= resp_vld_d;
            if (accept) begin
                resp_q <= resp_d;
            end
        end
    end

    assign resp_valid = resp_vld_q;
    assign resp_data  = resp_q.data;
    assign resp_id    = resp_q.id;
    assign resp_tag   = resp_q.tag[TAG_W-1:0];

    logic unused_tag_hi;
    assign unused_tag_hi = &{1'b0, resp_q.tag};

endmodule

// File: tb/tb_shift_arb.sv
// Randomized and directed checks of shift_arb against an arithmetic reference model.
module tb_shift_arb;

    localparam int TAG_W = 4;
`ifdef SHIFT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_srca = '0, req1_srca = '0;
    logic [4:0]       req0_srcb = '0, req1_srcb = '0;
    logic [1:0]       req0_func = '0, req1_func = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [31:0]      resp_data;
    logic             resp_id;
    logic [TAG_W-1:0] resp_tag;

    always #5 clk = ~clk;

    shift_arb #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_srca  (req0_srca),
        .req0_srcb  (req0_srcb),
        .req0_func  (req0_func),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_srca  (req1_srca),
        .req1_srcb  (req1_srcb),
        .req1_func  (req1_func),
        .req1_tag   (req1_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_tag   (resp_tag)
    );

    // Reference model state
    logic             m_vld, m_id, m_last;
    logic [31:0]      m_data;
    logic [TAG_W-1:0] m_tag;
    logic             exp_r0 = 1'b0, exp_r1 = 1'b0;
    int               n_vec = 0;
    int               n_err = 0;

    function automatic logic [31:0] ref_shift(logic [1:0] f, logic [31:0] a, logic [4:0] b);
        longint unsigned x, p, full;
        x    = 64'(a);
        p    = 64'd1 << b;
        full = 64'hFFFF_FFFF;
        case (f)
            2'b00:   return 32'((x % 65536) * 65536);
            2'b01:   return 32'((x * p) % (full + 1));
            2'b10:   return a[31] ? 32'(full - (full - x) / p) : 32'(x / p);
            default: return 32'(x / p);
        endcase
    endfunction

    function automatic void model_reset();
        m_vld  = 1'b0;
        m_data = '0;
        m_id   = 1'b0;
        m_tag  = '0;
        m_last = 1'b1;
    endfunction

    function automatic void model_pre();
        logic can, w;
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        can = (!m_vld || resp_ready) && !flush && !rst;
        if (can) begin
            if (req0_valid && req1_valid) begin
                w = RR ? !m_last : 1'b0;
                exp_r1 = w;
                exp_r0 = !w;
            end else begin
                exp_r0 = req0_valid;
                exp_r1 = req1_valid;
            end
        end
    endfunction

    function automatic void model_post();
        if (rst) begin
            model_reset();
        end else if (flush) begin
            m_vld = 1'b0;
        end else if (exp_r0 || exp_r1) begin
            m_vld  = 1'b1;
            m_id   = exp_r1;
            m_last = exp_r1;
            m_data = exp_r1 ? ref_shift(req1_func, req1_srca, req1_srcb)
                            : ref_shift(req0_func, req0_srca, req0_srcb);
            m_tag  = exp_r1 ? req1_tag : req0_tag;
        end else if (resp_ready) begin
            m_vld = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_post();
        #1;
    endtask

    task automatic set_req0(logic v, logic [1:0] f, logic [31:0] a, logic [4:0] b, logic [TAG_W-1:0] t);
        req0_valid = v; req0_func = f; req0_srca = a; req0_srcb = b; req0_tag = t;
    endtask

    task automatic set_req1(logic v, logic [1:0] f, logic [31:0] a, logic [4:0] b, logic [TAG_W-1:0] t);
        req1_valid = v; req1_func = f; req1_srca = a; req1_srcb = b; req1_tag = t;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_req0(1'b1, 2'b01, 32'h1, 5'd1, 4'h1);
        set_req1(1'b1, 2'b01, 32'h2, 5'd1, 4'h2);
        resp_ready = 1'b1;
        model_pre();
        #1;
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        n_vec++;
        if ({resp_valid, resp_data, resp_id, resp_tag} !== 38'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%0b d=%h id=%0b tag=%h want all zero",
                     resp_valid, resp_data, resp_id, resp_tag);
        end
        tick();
        n_vec++;
        if (resp_valid !== 1'b0 || {req0_ready, req1_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_held: got v=%0b rdy=%b want 0 / 00", resp_valid, {req0_ready, req1_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        set_req0(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
        set_req1(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    endtask

    task automatic test_rr_order();
        logic [1:0] want;
        for (int i = 0; i < 4; i++) begin
            set_req0(1'b1, 2'($urandom), $urandom, 5'($urandom), TAG_W'(i));
            set_req1(1'b1, 2'($urandom), $urandom, 5'($urandom), TAG_W'(i + 8));
            resp_ready = 1'b1;
            model_pre();
            #1;
            want = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
            n_vec++;
            if ({req1_ready, req0_ready} !== want) begin
                n_err++;
                $display("FAIL rr_order[%0d]: got {r1,r0}=%b want %b", i, {req1_ready, req0_ready}, want);
            end
            tick();
            n_vec++;
            if ({resp_valid, resp_data, resp_id, resp_tag} !== {m_vld, m_data, m_id, m_tag}) begin
                n_err++;
                $display("FAIL rr_resp[%0d]: got v=%0b d=%h id=%0b tag=%h want v=%0b d=%h id=%0b tag=%h",
                         i, resp_valid, resp_data, resp_id, resp_tag, m_vld, m_data, m_id, m_tag);
            end
            @(negedge clk);
        end
        set_req0(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
        set_req1(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    endtask

    task automatic test_sra();
        set_req0(1'b1, 2'b10, 32'h8000_0000, 5'd4, 4'd3);
        resp_ready = 1'b1;
        model_pre();
        #1;
        n_vec++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL sra_ready: got {r1,r0}=%b want 01", {req1_ready, req0_ready});
        end
        tick();
        n_vec++;
        if ({resp_valid, resp_data, resp_id, resp_tag} !== {1'b1, 32'hF800_0000, 1'b0, 4'd3}) begin
            n_err++;
            $display("FAIL sra_resp: got v=%0b d=%h id=%0b tag=%h want v=1 d=f8000000 id=0 tag=3",
                     resp_valid, resp_data, resp_id, resp_tag);
        end
        @(negedge clk);
        set_req0(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    endtask

    task automatic test_shift_edges();
        logic [1:0]  fs [4];
        logic [4:0]  bs [4];
        logic [31:0] ex [4];
        fs = '{2'b01, 2'b01, 2'b11, 2'b11};
        bs = '{5'd0, 5'd31, 5'd0, 5'd31};
        ex = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
        for (int i = 0; i < 4; i++) begin
            set_req0(1'b1, fs[i], 32'hFFFF_FFFF, bs[i], TAG_W'(i));
            resp_ready = 1'b1;
            model_pre();
            tick();
            n_vec++;
            if (resp_valid !== 1'b1 || resp_data !== ex[i]) begin
                n_err++;
                $display("FAIL shift_edge[%0d]: got v=%0b d=%h want v=1 d=%h", i, resp_valid, resp_data, ex[i]);
            end
            @(negedge clk);
        end
        set_req0(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    endtask

    task automatic test_backpressure();
        set_req1(1'b1, 2'b00, 32'h0000_1234, 5'd0, 4'd5);
        resp_ready = 1'b1;
        model_pre();
        tick();
        n_vec++;
        if ({resp_valid, resp_data, resp_id, resp_tag} !== {1'b1, 32'h1234_0000, 1'b1, 4'd5}) begin
            n_err++;
            $display("FAIL bp_fill: got v=%0b d=%h id=%0b tag=%h want v=1 d=12340000 id=1 tag=5",
                     resp_valid, resp_data, resp_id, resp_tag);
        end
        @(negedge clk);
        set_req1(1'b1, 2'b00, 32'h0000_1234, 5'd0, 4'd6);
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_pre();
            #1;
            n_vec++;
            if ({req1_ready, req0_ready} !== 2'b00) begin
                n_err++;
                $display("FAIL bp_ready[%0d]: got {r1,r0}=%b want 00", i, {req1_ready, req0_ready});
            end
            tick();
            n_vec++;
            if ({resp_valid, resp_data, resp_id, resp_tag} !== {1'b1, 32'h1234_0000, 1'b1, 4'd5}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%0b d=%h id=%0b tag=%h want v=1 d=12340000 id=1 tag=5",
                         i, resp_valid, resp_data, resp_id, resp_tag);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        model_pre();
        #1;
        n_vec++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL bp_refill_ready: got {r1,r0}=%b want 10", {req1_ready, req0_ready});
        end
        tick();
        n_vec++;
        if ({resp_valid, resp_data, resp_tag} !== {1'b1, 32'h1234_0000, 4'd6}) begin
            n_err++;
            $display("FAIL bp_refill: got v=%0b d=%h tag=%h want v=1 d=12340000 tag=6",
                     resp_valid, resp_data, resp_tag);
        end
        @(negedge clk);
        set_req1(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    endtask

    task automatic test_flush();
        set_req0(1'b1, 2'b01, $urandom, 5'($urandom), 4'd7);
        resp_ready = 1'b0;
        flush = 1'b1;
        model_pre();
        #1;
        n_vec++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL flush_ready: got {r1,r0}=%b want 00", {req1_ready, req0_ready});
        end
        tick();
        n_vec++;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear: got v=%0b want 0", resp_valid);
        end
        @(negedge clk);
        flush = 1'b0;
        set_req1(1'b1, 2'b11, $urandom, 5'($urandom), 4'd8);
        resp_ready = 1'b1;
        model_pre();
        #1;
        n_vec++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL flush_ptr: got {r1,r0}=%b want 01", {req1_ready, req0_ready});
        end
        tick();
        n_vec++;
        if ({resp_valid, resp_data, resp_id, resp_tag} !== {m_vld, m_data, m_id, m_tag}) begin
            n_err++;
            $display("FAIL flush_next: got v=%0b d=%h id=%0b tag=%h want v=%0b d=%h id=%0b tag=%h",
                     resp_valid, resp_data, resp_id, resp_tag, m_vld, m_data, m_id, m_tag);
        end
        @(negedge clk);
        set_req1(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    endtask

    task automatic test_rst_midstream();
        set_req0(1'b1, 2'b11, $urandom, 5'($urandom), 4'd9);
        resp_ready = 1'b1;
        model_pre();
        tick();
        @(negedge clk);
        set_req1(1'b1, 2'b10, $urandom, 5'($urandom), 4'd10);
        resp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({resp_valid, resp_data, resp_id, resp_tag, req0_ready, req1_ready} !== 40'h0) begin
            n_err++;
            $display("FAIL rst_async: got v=%0b d=%h id=%0b tag=%h rdy=%b want all zero",
                     resp_valid, resp_data, resp_id, resp_tag, {req1_ready, req0_ready});
        end
        model_reset();
        model_pre();
        tick();
        n_vec++;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_hold: got v=%0b want 0", resp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        model_pre();
        #1;
        n_vec++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL rst_first_grant: got {r1,r0}=%b want 01", {req1_ready, req0_ready});
        end
        tick();
        n_vec++;
        if ({resp_valid, resp_data, resp_id, resp_tag} !== {1'b1, m_data, 1'b0, 4'd9}) begin
            n_err++;
            $display("FAIL rst_first_resp: got v=%0b d=%h id=%0b tag=%h want v=1 d=%h id=0 tag=9",
                     resp_valid, resp_data, resp_id, resp_tag, m_data);
        end
        @(negedge clk);
        set_req0(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
        set_req1(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 600; it++) begin
            if (!req0_valid || exp_r0)
                set_req0(($urandom % 10) < 7, 2'($urandom), $urandom, 5'($urandom), TAG_W'($urandom));
            if (!req1_valid || exp_r1)
                set_req1(($urandom % 10) < 7, 2'($urandom), $urandom, 5'($urandom), TAG_W'($urandom));
            resp_ready = ($urandom % 10) < 7;
            flush = ($urandom % 16) == 0;
            model_pre();
            #1;
            n_vec++;
            if ({req1_ready, req0_ready} !== {exp_r1, exp_r0}) begin
                n_err++;
                $display("FAIL rand_ready[%0d]: got {r1,r0}=%b want %b", it, {req1_ready, req0_ready}, {exp_r1, exp_r0});
            end
            tick();
            n_vec++;
            if (resp_valid !== m_vld ||
                (m_vld && {resp_data, resp_id, resp_tag} !== {m_data, m_id, m_tag})) begin
                n_err++;
                $display("FAIL rand_resp[%0d]: got v=%0b d=%h id=%0b tag=%h want v=%0b d=%h id=%0b tag=%h",
                         it, resp_valid, resp_data, resp_id, resp_tag, m_vld, m_data, m_id, m_tag);
            end
            @(negedge clk);
        end
        flush = 1'b0;
        set_req0(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
        set_req1(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_rr_order();
        test_sra();
        test_shift_edges();
        test_backpressure();
        test_flush();
        test_rst_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
